risc_v_pc_unit: RTL and testbench

Parametrised program-counter unit for the RISC-V core's fetch stage. It is the successor to the plain PC register and owns next-PC selection: sequential, branch/jump redirect, trap entry, `mret` return and misaligned-target faulting. It issues fetch addresses to instruction memory over a valid/ready handshake and buffers control-flow events that arrive while a fetch is stalled. It sits between the execute stage's redirect logic, the trap/CSR logic and the instruction-memory port.

---
 rtl/risc_v_pkg.sv | 23 ++
 rtl/risc_v_npc_sel.sv | 62 ++++++
 rtl/risc_v_pc_unit.sv | 170 +++++++++++++++++
 tb/tb_risc_v_pc_unit.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_v_pkg.sv
// Shared types for the fetch-stage program-counter unit.
//   state_e : PC unit control state (IDLE/RUN/HOLD)
//   prio_e  : control-flow event priority, higher value wins
//   DEFAULT_TRAP_VECTOR : default trap / misaligned-fault entry address
package risc_v_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // A misaligned redirect is promoted to PRIO_TRAP.
  typedef enum logic [1:0] {
    PRIO_NONE     = 2'd0,
    PRIO_REDIRECT = 2'd1,
    PRIO_MRET     = 2'd2,
    PRIO_TRAP     = 2'd3
  } prio_e;

  localparam logic [31:0] DEFAULT_TRAP_VECTOR = 32'h0000_0100;

endpackage

// File: rtl/risc_v_npc_sel.sv
// Next-target selection: resolves same-cycle control-flow events by
// priority (trap > mret > redirect) and converts a misaligned redirect
// into a trap-class event. Purely combinational.
//   trap_valid_i, mret_i, redirect_valid_i : event requests
//   redirect_target_i : redirect destination
//   epc_i             : saved exception PC (mret target source)
//   ev_valid_c_o      : some event is present this cycle
//   ev_prio_c_o       : priority class of the winning event
//   ev_target_c_o     : PC the winning event resolves to
//   ev_misalign_c_o   : winning event is a misaligned redirect
module risc_v_npc_sel
  import risc_v_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] TRAP_VECTOR = ADDR_WIDTH'(DEFAULT_TRAP_VECTOR),
  parameter int unsigned           INC         = 4
) (
  input  logic                  trap_valid_i,
  input  logic                  mret_i,
  input  logic                  redirect_valid_i,
  input  logic [ADDR_WIDTH-1:0] redirect_target_i,
  input  logic [ADDR_WIDTH-1:0] epc_i,
  output logic                  ev_valid_c_o,
  output prio_e                 ev_prio_c_o,
  output logic [ADDR_WIDTH-1:0] ev_target_c_o,
  output logic                  ev_misalign_c_o
);

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(INC - 1);

  logic redirect_misaligned;

  assign redirect_misaligned = |(redirect_target_i & ALIGN_MASK);

  // Priority select; the alignment check only matters when redirect wins.
  always_comb begin
    ev_valid_c_o    = 1'b0;
    ev_prio_c_o     = PRIO_NONE;
    ev_target_c_o   = '0;
    ev_misalign_c_o = 1'b0;
    if (trap_valid_i) begin
      ev_valid_c_o  = 1'b1;
      ev_prio_c_o   = PRIO_TRAP;
      ev_target_c_o = TRAP_VECTOR;
    end else if (mret_i) begin
      ev_valid_c_o  = 1'b1;
      ev_prio_c_o   = PRIO_MRET;
      ev_target_c_o = epc_i & ~ALIGN_MASK;
    end else if (redirect_valid_i) begin
      ev_valid_c_o = 1'b1;
      if (redirect_misaligned) begin
        ev_prio_c_o     = PRIO_TRAP;
        ev_target_c_o   = TRAP_VECTOR;
        ev_misalign_c_o = 1'b1;
      end else begin
        ev_prio_c_o   = PRIO_REDIRECT;
        ev_target_c_o = redirect_target_i;
      end
    end
  end

endmodule

// File: rtl/risc_v_pc_unit.sv
// Fetch-stage program-counter unit: next-PC selection, fetch issue over a
// valid/ready handshake, buffering of control-flow events while a fetch is
// outstanding, trap/mret/misaligned-fault handling.
//   clk, reset (sync, active-low)
//   stall                         : blocks issue of a new fetch
//   redirect_valid/target         : taken branch/jump
//   trap_valid/trap_pc            : exception entry, trap_pc saved to epc
//   mret                          : return to epc
//   fetch_valid/fetch_ready/fetch_pc : instruction-memory request
//   pc, epc, badaddr              : architectural registers
//   misalign_fault                : one-cycle pulse per misaligned redirect
module risc_v_pc_unit
  import risc_v_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [ADDR_WIDTH-1:0] TRAP_VECTOR  = ADDR_WIDTH'(DEFAULT_TRAP_VECTOR),
  parameter int unsigned           INC          = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_target,
  input  logic                  trap_valid,
  input  logic [ADDR_WIDTH-1:0] trap_pc,
  input  logic                  mret,
  output logic                  fetch_valid,
  input  logic                  fetch_ready,
  output logic [ADDR_WIDTH-1:0] fetch_pc,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] epc,
  output logic [ADDR_WIDTH-1:0] badaddr,
  output logic                  misalign_fault
);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] epc_q, epc_d;
  logic [ADDR_WIDTH-1:0] badaddr_q, badaddr_d;
  logic [ADDR_WIDTH-1:0] pend_q, pend_d;
  prio_e                 pend_prio_q, pend_prio_d;
  logic                  misalign_q, misalign_d;
  logic                  outst_q;

  logic                  ev_valid_c;
  prio_e                 ev_prio_c;
  logic [ADDR_WIDTH-1:0] ev_target_c;
  logic                  ev_misalign_c;

  logic                  fetch_valid_c;
  logic                  accept_c;
  logic                  outst_c;
  logic                  take_c;

  risc_v_npc_sel #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .TRAP_VECTOR(TRAP_VECTOR),
    .INC        (INC)
  ) u_npc_sel (
    .trap_valid_i     (trap_valid),
    .mret_i           (mret),
    .redirect_valid_i (redirect_valid),
    .redirect_target_i(redirect_target),
    .epc_i            (epc_q),
    .ev_valid_c_o     (ev_valid_c),
    .ev_prio_c_o      (ev_prio_c),
    .ev_target_c_o    (ev_target_c),
    .ev_misalign_c_o  (ev_misalign_c)
  );

  // Handshake status and event acceptance. Once raised, valid is held by
  // the registered outstanding flag regardless of stall.
  always_comb begin
    fetch_valid_c = (state_q != ST_IDLE) && (!stall || outst_q);
    accept_c      = fetch_valid_c && fetch_ready;
    outst_c       = fetch_valid_c && !fetch_ready;
    take_c        = 1'b0;
    if (ev_valid_c) begin
      if (state_q == ST_RUN) begin
        take_c = 1'b1;
      end else if (state_q == ST_HOLD) begin
        take_c = (ev_prio_c >= pend_prio_q);
      end
    end
  end

  // Next-state datapath: CSR-like registers update when the event is
  // taken, the PC change itself may be deferred into the pending register.
  always_comb begin
    pc_d        = pc_q;
    epc_d       = epc_q;
    badaddr_d   = badaddr_q;
    pend_d      = pend_q;
    pend_prio_d = pend_prio_q;
    misalign_d  = 1'b0;

    if (take_c) begin
      misalign_d = ev_misalign_c;
      if (ev_misalign_c) begin
        badaddr_d = redirect_target;
        epc_d     = pc_q;
      end else if (trap_valid) begin
        epc_d = trap_pc;
      end
    end

    case (state_q)
      ST_RUN: begin
        if (take_c) begin
          if (outst_c) begin
            pend_d      = ev_target_c;
            pend_prio_d = ev_prio_c;
          end else begin
            pc_d = ev_target_c;
          end
        end else if (accept_c) begin
          pc_d = pc_q + ADDR_WIDTH'(INC);
        end
      end
      ST_HOLD: begin
        if (take_c) begin
          pend_d      = ev_target_c;
          pend_prio_d = ev_prio_c;
        end
        if (accept_c) begin
          pc_d        = take_c ? ev_target_c : pend_q;
          pend_prio_d = PRIO_NONE;
        end
      end
      default: ;
    endcase
  end

  // State machine and register bank.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_VECTOR;
      epc_q       <= '0;
      badaddr_q   <= '0;
      pend_q      <= '0;
      pend_prio_q <= PRIO_NONE;
      misalign_q  <= 1'b0;
      outst_q     <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      epc_q       <= epc_d;
      badaddr_q   <= badaddr_d;
      pend_q      <= pend_d;
      pend_prio_q <= pend_prio_d;
      misalign_q  <= misalign_d;
      outst_q     <= outst_c;
      case (state_q)
        ST_IDLE: state_q <= ST_RUN;
        ST_RUN:  if (take_c && outst_c) state_q <= ST_HOLD;
        ST_HOLD: if (accept_c) state_q <= ST_RUN;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign fetch_valid    = fetch_valid_c;
  assign fetch_pc       = pc_q;
  assign pc             = pc_q;
  assign epc            = epc_q;
  assign badaddr        = badaddr_q;
  assign misalign_fault = misalign_q;

endmodule

// File: tb/tb_risc_v_pc_unit.sv
// Scoreboard bench for risc_v_pc_unit: directed scenarios followed by
// random stimulus, checked against a behavioural model of the PC unit.
module tb_risc_v_pc_unit;

  localparam logic [31:0] RV  = 32'h0000_1000;
  localparam logic [31:0] TV  = 32'h0000_0100;
  localparam int unsigned INC = 4;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        trap_valid;
  logic [31:0] trap_pc;
  logic        mret;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_pc;
  logic [31:0] pc;
  logic [31:0] epc;
  logic [31:0] badaddr;
  logic        misalign_fault;

  risc_v_pc_unit #(
    .ADDR_WIDTH  (32),
    .RESET_VECTOR(RV),
    .TRAP_VECTOR (TV),
    .INC         (INC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .trap_valid     (trap_valid),
    .trap_pc        (trap_pc),
    .mret           (mret),
    .fetch_valid    (fetch_valid),
    .fetch_ready    (fetch_ready),
    .fetch_pc       (fetch_pc),
    .pc             (pc),
    .epc            (epc),
    .badaddr        (badaddr),
    .misalign_fault (misalign_fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [31:0] exp_q[$];
  bit          exp_fv = 1'b0;
  bit          mon_en = 1'b0;

  // Behavioural model state (values visible after the last clock edge).
  logic [31:0] m_pc, m_epc, m_bad, m_pend_t;
  bit          m_fault, m_started, m_outst, m_pend_v;
  int          m_pend_r;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc      = RV;
    m_epc     = '0;
    m_bad     = '0;
    m_fault   = 1'b0;
    m_started = 1'b0;
    m_outst   = 1'b0;
    m_pend_v  = 1'b0;
    m_pend_t  = '0;
    m_pend_r  = 0;
  endtask

  // One clock cycle: check registered outputs against the model, drive new
  // inputs, record the expected handshake and advance the model.
  task automatic step(input bit rst_a, input bit st, input bit rdy,
                      input bit rv, input logic [31:0] rt,
                      input bit tv, input logic [31:0] tpc, input bit mr);
    bit          fv, acc, ev, mis, take, fault_n;
    int          rank;
    logic [31:0] tgt;
    @(negedge clk);
    mon_en = 1'b1;
    check("pc", pc, m_pc);
    check("fetch_pc", fetch_pc, m_pc);
    check("epc", epc, m_epc);
    check("badaddr", badaddr, m_bad);
    check("misalign_fault", 32'(misalign_fault), 32'(m_fault));

    fv     = m_started && (!st || m_outst);
    acc    = fv && rdy;
    exp_fv = fv;
    if (acc) exp_q.push_back(m_pc);

    reset           = !rst_a;
    stall           = st;
    fetch_ready     = rdy;
    redirect_valid  = rv;
    redirect_target = rt;
    trap_valid      = tv;
    trap_pc         = tpc;
    mret            = mr;

    if (rst_a) begin
      model_reset();
      return;
    end

    ev = 1'b1; mis = 1'b0; rank = 0; tgt = '0;
    if (tv) begin
      rank = 3; tgt = TV;
    end else if (mr) begin
      rank = 2; tgt = m_epc - (m_epc % INC);
    end else if (rv) begin
      if (rt % INC != 0) begin
        rank = 3; tgt = TV; mis = 1'b1;
      end else begin
        rank = 1; tgt = rt;
      end
    end else begin
      ev = 1'b0;
    end

    fault_n = 1'b0;
    if (!m_started) begin
      m_started = 1'b1;
    end else begin
      take = ev && (!m_pend_v || rank >= m_pend_r);
      if (take) begin
        fault_n = mis;
        if (tv) m_epc = tpc;
        else if (mis) begin
          m_epc = m_pc;
          m_bad = rt;
        end
      end
      if (m_pend_v) begin
        if (take) begin
          m_pend_t = tgt; m_pend_r = rank;
        end
        if (acc) begin
          m_pc = m_pend_t; m_pend_v = 1'b0;
        end
      end else if (take) begin
        if (fv && !rdy) begin
          m_pend_v = 1'b1; m_pend_t = tgt; m_pend_r = rank;
        end else begin
          m_pc = tgt;
        end
      end else if (acc) begin
        m_pc = m_pc + 32'(INC);
      end
    end
    m_fault = fault_n;
    m_outst = fv && !rdy;
  endtask

  task automatic cyc(input bit st, input bit rdy);
    step(1'b0, st, rdy, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares fetch_valid each cycle and pops the scoreboard on
  // every accepted fetch.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #4;
      if (mon_en) begin
        check("fetch_valid", 32'(fetch_valid), 32'(exp_fv));
        if (fetch_valid && fetch_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept: fetch of 0x%08h accepted, none expected at %0t", fetch_pc, $time);
          end else begin
            e = exp_q.pop_front();
            check("accepted_fetch_pc", fetch_pc, e);
          end
        end
      end
    end
  end

  initial begin
    bit          r_rst, r_st, r_rdy, r_rv, r_tv, r_mr;
    logic [31:0] r_rt;
    reset = 1'b0; stall = 1'b0; fetch_ready = 1'b0;
    redirect_valid = 1'b0; redirect_target = '0;
    trap_valid = 1'b0; trap_pc = '0; mret = 1'b0;
    model_reset();

    // Reset and sequential fetch.
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    settle();
    check("rst_pc", pc, 32'h0000_1000);
    check("rst_epc", epc, 32'h0);
    check("rst_badaddr", badaddr, 32'h0);
    check("rst_fault", 32'(misalign_fault), 32'h0);
    check("rst_fetch_valid", 32'(fetch_valid), 32'h0);
    cyc(1'b0, 1'b1);
    settle();
    check("first_fetch_valid", 32'(fetch_valid), 32'h1);
    check("first_fetch_pc", fetch_pc, 32'h0000_1000);
    repeat (3) cyc(1'b0, 1'b1);
    settle();
    check("seq_pc", pc, 32'h0000_100C);

    // Redirect while a fetch is outstanding.
    cyc(1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_2000, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    settle();
    check("held_fetch_pc", fetch_pc, 32'h0000_100C);
    check("held_fetch_valid", 32'(fetch_valid), 32'h1);
    cyc(1'b0, 1'b1);
    settle();
    check("deferred_redirect_pc", pc, 32'h0000_2000);

    // Misaligned redirect.
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_2002, 1'b0, '0, 1'b0);
    settle();
    check("mis_pc", pc, TV);
    check("mis_badaddr", badaddr, 32'h0000_2002);
    check("mis_epc", epc, 32'h0000_2000);
    check("mis_fault_hi", 32'(misalign_fault), 32'h1);
    cyc(1'b1, 1'b0);
    settle();
    check("mis_fault_lo", 32'(misalign_fault), 32'h0);

    // Trap beats redirect; mret returns to epc.
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_4000, 1'b1, 32'h0000_0300, 1'b0);
    settle();
    check("trap_pc", pc, TV);
    check("trap_epc", epc, 32'h0000_0300);
    step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    settle();
    check("mret_pc", pc, 32'h0000_0300);

    // Wrap.
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b1);
    settle();
    check("wrap_pc", pc, 32'h0);

    // Stall during and outside a handshake.
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    settle();
    check("stall_hold_valid", 32'(fetch_valid), 32'h1);
    check("stall_hold_pc", fetch_pc, 32'h0);
    cyc(1'b1, 1'b1);
    settle();
    check("stall_after_accept_pc", pc, 32'h4);
    check("stall_idle_valid", 32'(fetch_valid), 32'h0);
    cyc(1'b1, 1'b1);
    settle();
    check("stall_idle_pc", pc, 32'h4);

    // Reset in the middle of a handshake.
    cyc(1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    settle();
    check("midrst_valid", 32'(fetch_valid), 32'h0);
    check("midrst_pc", pc, RV);
    check("midrst_epc", epc, 32'h0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      r_rst = ($urandom_range(0, 99) == 0);
      r_st  = ($urandom_range(0, 3) == 0);
      r_rdy = r_rst ? 1'b0 : ($urandom_range(0, 2) != 0);
      r_rv  = ($urandom_range(0, 4) == 0);
      r_tv  = ($urandom_range(0, 19) == 0);
      r_mr  = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 4))
        0:       r_rt = $urandom() & 32'hFFFF_FFFC;
        1:       r_rt = $urandom() | 32'h0000_0001;
        2:       r_rt = 32'hFFFF_FFF8;
        3:       r_rt = 32'h0000_2002;
        default: r_rt = 32'h0000_2000;
      endcase
      step(r_rst, r_st, r_rdy, r_rv, r_rt, r_tv, $urandom(), r_mr);
    end
    cyc(1'b1, 1'b0);
    #5;
    mon_en = 1'b0;
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
